// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite single-port SRAM slave.
//   Word-organised memory of MEM_DEPTH x 32 bits at BASE_ADDR. It supports byte,
//   halfword and word accesses, WAIT_STATES wait cycles per OKAY data phase, and
//   the two-cycle ERROR response for out-of-range, oversize or misaligned accesses.
//
// Ports:
//   HCLK, HRESETn         clock, synchronous active-low reset
//   HSEL, HADDR, HTRANS,  address-phase controls, accepted when
//   HWRITE, HSIZE, HREADY   HSEL & HREADY & HTRANS[1]
//   HWDATA                write data (data phase)
//   HREADYOUT, HRESP      slave ready / response
//   HRDATA                read data, zero outside a read data phase
//
// Optional feature, compile-time macro AHB_SRAM_STATS_EN:
//   adds stat_rd_cnt / stat_wr_cnt / stat_err_cnt. These are saturating 16-bit
//   counts of OKAY reads, OKAY writes and ERR2 cycles.
module ahb_sram_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [DATA_WIDTH-1:0] HRDATA
`ifdef AHB_SRAM_STATS_EN
    ,
    output logic [15:0]           stat_rd_cnt,
    output logic [15:0]           stat_wr_cnt,
    output logic [15:0]           stat_err_cnt
`endif
);

    localparam int                    IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(MEM_DEPTH * 4);
    // Only used when WAIT_STATES > 0, so the wrap for 0 is harmless.
    localparam logic [3:0]            WAIT_LOAD = 4'(WAIT_STATES - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t            state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] offset;
    logic                  accept;
    logic                  illegal;
    logic [3:0]            be;
    logic                  mem_we;
    logic                  unused_trans;

    // HTRANS[0] only separates BUSY from IDLE and NONSEQ from SEQ. Neither
    // distinction matters here because every beat is handled on its own.
    assign unused_trans = HTRANS[0];

    // BASE_ADDR is aligned, so alignment can be checked on the offset.
    // An address below the base wraps to a huge offset and is rejected as out of range.
    assign offset  = HADDR - BASE_ADDR;
    assign accept  = HSEL & HREADY & HTRANS[1];
    assign illegal = (offset >= MEM_BYTES) | (HSIZE > 3'd2) |
                     ((HSIZE == 3'd1) & offset[0]) |
                     ((HSIZE == 3'd2) & (offset[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        write_d   = write_q;
        size_d    = size_q;
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;

        case (state_q)
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (wcnt_q == 4'd0) state_d = S_DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
                state_d   = S_ERR2;
            end
            S_ERR2: begin
                HRESP   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;   // S_IDLE and S_DATA
        endcase

        // A new address phase can only complete while HREADYOUT is high.
        // That is the case in IDLE, DATA (pipelined back-to-back) and ERR2.
        if (HREADYOUT && accept) begin
            idx_d   = offset[IDX_W+1:2];
            lane_d  = offset[1:0];
            write_d = HWRITE;
            size_d  = HSIZE;
            if (illegal) begin
                state_d = S_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = S_WAIT;
                wcnt_d  = WAIT_LOAD;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            write_q <= write_d;
            size_q  <= size_d;
        end
    end

    // Little-endian lane enables. Only legal sizes ever reach DATA.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            3'd0:    be = 4'b0001 << lane_q;
            3'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // The write commits on the edge that leaves DATA, so a read pipelined right
    // behind it sees the new word. Reset at that edge abandons the write.
    assign mem_we = (state_q == S_DATA) & write_q & HRESETn;

    always_ff @(posedge HCLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

    assign HRDATA = ((state_q == S_DATA) && !write_q) ? mem[idx_q] : '0;

`ifdef AHB_SRAM_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
        return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        rd_cnt_d  = sat_inc(rd_cnt_q,  (state_q == S_DATA) & ~write_q);
        wr_cnt_d  = sat_inc(wr_cnt_q,  (state_q == S_DATA) &  write_q);
        err_cnt_d = sat_inc(err_cnt_q, (state_q == S_ERR2));
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave. It has two instances: dut0 with WAIT_STATES=0 and
// MEM_DEPTH=1024, and dut2 with WAIT_STATES=2 and MEM_DEPTH=2048. They share one
// driven bus, and 'sel' picks which instance HSEL reaches and whose outputs are
// observed. Expected responses are pushed to a scoreboard when an address phase
// is accepted, and popped when the data phase completes.
module tb_ahb_sram_slave;

    logic        hclk = 1'b0;
    logic        hrst_n;
    logic        sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;

    logic        ho0, hp0, ho2, hp2;
    logic [31:0] hd0, hd2;
    logic        obs_hr, obs_hp;
    logic [31:0] obs_hd;

    always #5 hclk = ~hclk;

    assign obs_hr = sel ? ho2 : ho0;
    assign obs_hp = sel ? hp2 : hp0;
    assign obs_hd = sel ? hd2 : hd0;

`ifdef AHB_SRAM_STATS_EN
    logic [15:0] rd0, wr0, er0, rd2, wr2, er2;
`endif

    ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0)) dut0 (
        .HCLK(hclk), .HRESETn(hrst_n), .HSEL(hsel & ~sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(ho0), .HREADYOUT(ho0), .HRESP(hp0), .HRDATA(hd0)
`ifdef AHB_SRAM_STATS_EN
        , .stat_rd_cnt(rd0), .stat_wr_cnt(wr0), .stat_err_cnt(er0)
`endif
    );

    ahb_sram_slave #(.MEM_DEPTH(2048), .WAIT_STATES(2)) dut2 (
        .HCLK(hclk), .HRESETn(hrst_n), .HSEL(hsel & sel), .HADDR(haddr),
        .HTRANS(htrans), .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
        .HREADY(ho2), .HREADYOUT(ho2), .HRESP(hp2), .HRDATA(hd2)
`ifdef AHB_SRAM_STATS_EN
        , .stat_rd_cnt(rd2), .stat_wr_cnt(wr2), .stat_err_cnt(er2)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    typedef struct packed {
        logic        err;
        logic        rd;
        logic [31:0] rdata;
    } exp_t;

    op_t         ops[$];
    exp_t        sb[$];
    logic [31:0] mdl [4096];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic is_err(input logic s, input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] lim;
        lim = s ? 32'd8192 : 32'd4096;
        return (a >= lim) || (sz > 3'd2) || (sz == 3'd1 && a[0]) ||
               (sz == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic int widx(input logic s, input logic [31:0] a);
        return (s ? 2048 : 0) + int'(a[12:2]);
    endfunction

    task automatic model_write(input op_t o);
        int          w;
        logic [31:0] v;
        w = widx(sel, o.addr);
        v = mdl[w];
        for (int b = 0; b < 4; b++) begin
            if ((o.size == 3'd2) ||
                (o.size == 3'd1 && (b >> 1) == int'(o.addr[1])) ||
                (o.size == 3'd0 && b == int'(o.addr[1:0])))
                v[8*b +: 8] = o.wdata[8*b +: 8];
        end
        mdl[w] = v;
    endtask

    task automatic push_op(input logic [31:0] a, input logic [1:0] tr, input logic wr,
                           input logic [2:0] sz, input logic [31:0] wd);
        op_t o;
        o.addr = a; o.trans = tr; o.write = wr; o.size = sz; o.wdata = wd;
        ops.push_back(o);
    endtask

    // Runs the queued ops as a pipelined AHB sequence. It is entered and left
    // just after a rising edge, and returns the number of data-phase cycles.
    task automatic run_ops(output int dpc);
        op_t         cur;
        exp_t        e;
        logic        dp_v, dp_err;
        logic [31:0] dp_wd;
        int          dp_cyc, budget, ws;
        logic        hr, hp, exp_hr;
        logic [31:0] hd;
        dp_v = 1'b0; dp_err = 1'b0; dp_wd = '0; dp_cyc = 0; budget = 400; dpc = 0;
        ws = sel ? 2 : 0;
        while ((ops.size() > 0 || dp_v) && budget > 0) begin
            budget--;
            if (ops.size() > 0) begin
                cur = ops[0];
                hsel = 1'b1; haddr = cur.addr; htrans = cur.trans;
                hwrite = cur.write; hsize = cur.size;
            end else begin
                hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = '0;
            end
            hwdata = dp_v ? dp_wd : 32'h0;
            @(negedge hclk);
            hr = obs_hr; hp = obs_hp; hd = obs_hd;
            if (dp_v) exp_hr = dp_err ? (dp_cyc == 1) : (dp_cyc == ws);
            else      exp_hr = 1'b1;
            chk("hreadyout", {31'b0, hr}, {31'b0, exp_hr});
            chk("hresp", {31'b0, hp}, {31'b0, dp_v & dp_err});
            if (dp_v && hr && sb.size() > 0) begin
                e = sb.pop_front();
                chk("done_resp", {31'b0, hp}, {31'b0, e.err});
                chk("latency", dp_cyc + 1, e.err ? 2 : ws + 1);
                chk("hrdata", hd, (e.rd && !e.err) ? e.rdata : 32'h0);
            end else begin
                chk("hrdata_idle", hd, 32'h0);
            end
            if (dp_v) begin dpc++; dp_cyc++; end
            @(posedge hclk); #1;
            if (hr) begin
                dp_v = 1'b0;
                if (ops.size() > 0) begin
                    cur = ops.pop_front();
                    e.err = is_err(sel, cur.addr, cur.size);
                    e.rd  = ~cur.write;
                    if (!e.err && cur.write) model_write(cur);
                    e.rdata = e.err ? 32'h0 : mdl[widx(sel, cur.addr)];
                    sb.push_back(e);
                    dp_v = 1'b1; dp_err = e.err; dp_wd = cur.wdata; dp_cyc = 0;
                end
            end
        end
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0;
        if (budget == 0) chk("timeout", 32'd1, 32'd0);
        chk("sb_empty", sb.size(), 0);
        ops.delete();
        sb.delete();
    endtask

    initial begin
        int n;
        foreach (mdl[i]) mdl[i] = 32'h0;
        hrst_n = 1'b0; sel = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
        hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
        repeat (3) @(posedge hclk);
        #1 hrst_n = 1'b1;
        @(negedge hclk);
        chk("rst_hready0", {31'b0, ho0}, 32'd1);
        chk("rst_hresp0", {31'b0, hp0}, 32'd0);
        chk("rst_hrdata0", hd0, 32'h0);
        chk("rst_hready2", {31'b0, ho2}, 32'd1);
        chk("rst_hresp2", {31'b0, hp2}, 32'd0);
        chk("rst_hrdata2", hd2, 32'h0);
        @(posedge hclk); #1;

`ifdef AHB_SRAM_STATS_EN
        chk("rst_stat_rd", {16'b0, rd0}, 32'd0);
        chk("rst_stat_err", {16'b0, er0}, 32'd0);
        push_op(32'h10, 2'b10, 1'b1, 3'd2, 32'hA1A1_0001);
        push_op(32'h14, 2'b10, 1'b1, 3'd2, 32'hA1A1_0002);
        push_op(32'h10, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h14, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h10, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h1000, 2'b10, 1'b0, 3'd2, 32'h0);
        run_ops(n);
        chk("stat_rd", {16'b0, rd0}, 32'd3);
        chk("stat_wr", {16'b0, wr0}, 32'd2);
        chk("stat_err", {16'b0, er0}, 32'd1);
`endif

        // Zero wait states: a word write, then a back-to-back read of the same word.
        push_op(32'h200, 2'b10, 1'b1, 3'd2, 32'hDEAD_BEEF);
        push_op(32'h200, 2'b10, 1'b0, 3'd2, 32'h0);
        run_ops(n);
        chk("t1_dp_cycles", n, 2);

        // Byte and halfword lane placement.
        push_op(32'h100, 2'b10, 1'b1, 3'd2, 32'h0);
        push_op(32'h101, 2'b10, 1'b1, 3'd0, 32'h0000_A500);
        push_op(32'h100, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h102, 2'b10, 1'b1, 3'd1, 32'hBEEF_0000);
        push_op(32'h100, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h103, 2'b10, 1'b1, 3'd0, 32'h7700_0000);
        push_op(32'h100, 2'b10, 1'b0, 3'd2, 32'h0);
        run_ops(n);

        // Errors: out of range, misaligned word/half, oversize; memory untouched.
        push_op(32'h1000, 2'b10, 1'b0, 3'd2, 32'h0);
        push_op(32'h202,  2'b10, 1'b1, 3'd2, 32'h1111_1111);
        push_op(32'h201,  2'b10, 1'b1, 3'd1, 32'h2222_2222);
        push_op(32'h204,  2'b10, 1'b1, 3'd3, 32'h3333_3333);
        push_op(32'h200,  2'b10, 1'b0, 3'd2, 32'h0);
        run_ops(n);
        chk("t4_mem_kept", mdl[widx(1'b0, 32'h200)], 32'hDEAD_BEEF);

        // Two wait states: preload four words, then an INCR4 read burst.
        sel = 1'b1;
        for (int i = 0; i < 4; i++)
            push_op(32'h1000 + 32'(4 * i), 2'b10, 1'b1, 3'd2, 32'hC0DE_0000 + 32'(i));
        run_ops(n);
        for (int i = 0; i < 4; i++)
            push_op(32'h1000 + 32'(4 * i), (i == 0) ? 2'b10 : 2'b11, 1'b0, 3'd2, 32'h0);
        run_ops(n);
        chk("t3_burst_cycles", n, 12);

        // Reset during the WAIT cycle of a write abandons that write.
        push_op(32'h40, 2'b10, 1'b1, 3'd2, 32'h1234_5678);
        run_ops(n);
        hsel = 1'b1; haddr = 32'h40; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_FFFF; hrst_n = 1'b0;
        @(posedge hclk); #1;
        hrst_n = 1'b1; hwdata = 32'h0;
        @(negedge hclk);
        chk("t5_hready", {31'b0, ho2}, 32'd1);
        chk("t5_hresp", {31'b0, hp2}, 32'd0);
        @(posedge hclk); #1;
        push_op(32'h40, 2'b10, 1'b0, 3'd2, 32'h0);
        run_ops(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
